// File: rtl/menu_select_controller_pkg.sv
// rtl/menu_select_controller_pkg.sv - option codes, FSM states and cursor navigation for the main menu
package menu_select_controller_pkg;

  // Menu option codes; the main-menu pixel processor decodes the same values.
  localparam logic [2:0] OPT_PLAY1P  = 3'd0;
  localparam logic [2:0] OPT_ENDLESS = 3'd1;
  localparam logic [2:0] OPT_PLAY2P  = 3'd2;
  localparam logic [2:0] OPT_TOP1P   = 3'd3;
  localparam logic [2:0] OPT_TOPEND  = 3'd4;

  // Button slots in the debounced level/event vectors.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;
  localparam int NUM_BTNS  = 5;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_GAME   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NAV_UP   = 2'd0,
    NAV_DOWN = 2'd1,
    NAV_SIDE = 2'd2
  } nav_t;

  // Left column holds PLAY1P/ENDLESS/PLAY2P (rows 0-2), right column TOP1P/TOPEND (rows 0-1).
  // Sideways moves keep the row; row 2 has no right-hand partner and lands on TOPEND.
  function automatic logic [2:0] nav_next(input logic [2:0] sel, input nav_t dir);
    logic       right_col;
    logic [2:0] res;
    right_col = (sel >= OPT_TOP1P);
    res       = sel;
    case (dir)
      NAV_UP: begin
        if (right_col)                res = (sel == OPT_TOP1P) ? OPT_TOPEND : OPT_TOP1P;
        else if (sel == OPT_PLAY1P)   res = OPT_PLAY2P;
        else                          res = sel - 3'd1;
      end
      NAV_DOWN: begin
        if (right_col)                res = (sel == OPT_TOP1P) ? OPT_TOPEND : OPT_TOP1P;
        else if (sel == OPT_PLAY2P)   res = OPT_PLAY1P;
        else                          res = sel + 3'd1;
      end
      default: begin
        if (right_col)                res = (sel == OPT_TOP1P) ? OPT_PLAY1P : OPT_ENDLESS;
        else                          res = (sel == OPT_PLAY1P) ? OPT_TOP1P : OPT_TOPEND;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, stability counter, debounced level and rise pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // Synchronize, then accept a new level only after it has been seen DEBOUNCE_CYCLES+1 times in a row.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/menu_select_controller.sv
// rtl/menu_select_controller.sv - menu cursor and game-launch handshake; MENU_AUTOREPEAT_EN adds up/down auto-repeat
module menu_select_controller
  import menu_select_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 6250000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       game_done,
  output logic [2:0] menu_sel,
  output logic       menu_active,
  output logic [2:0] game_mode,
  output logic       game_start,
  output logic       in_game
);

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_lvl;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] w_evt;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [2:0] r_mode;
  logic [2:0] w_mode_nxt;
  logic       r_start;
  logic       r_in_game;
  logic       r_active;

  assign w_raw = {btn_select, btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .resetn  (resetn),
      .i_raw   (w_raw[gi]),
      .o_level (w_lvl[gi]),
      .o_rise  (w_rise[gi])
    );
  end

`ifdef MENU_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [1:0] w_rpt_fire;

  for (genvar gr = 0; gr < 2; gr++) begin : g_rpt
    logic [RPT_W-1:0] r_cnt;
    logic             r_first;

    assign w_rpt_fire[gr] = w_lvl[gr] &
                            (r_first ? (r_cnt == RPT_W'(REPEAT_DELAY - 1))
                                     : (r_cnt == RPT_W'(REPEAT_PERIOD - 1)));

    // Count held cycles of up/down; first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (!w_lvl[gr]) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (w_rpt_fire[gr]) begin
        r_cnt   <= '0;
        r_first <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_evt = w_rise | {3'b000, w_rpt_fire};
`else
  logic w_unused_repeat;
  assign w_unused_repeat = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign w_evt = w_rise;
`endif

  // Next state, cursor and latched mode; one event per cycle, select > up > down > left > right.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_mode_nxt  = r_mode;
    case (r_state)
      ST_MENU: begin
        if (w_evt[BTN_SEL]) begin
          w_mode_nxt  = r_sel;
          w_state_nxt = ST_ARMED;
        end else if (w_evt[BTN_UP]) begin
          w_sel_nxt = nav_next(r_sel, NAV_UP);
        end else if (w_evt[BTN_DOWN]) begin
          w_sel_nxt = nav_next(r_sel, NAV_DOWN);
        end else if (w_evt[BTN_LEFT] || w_evt[BTN_RIGHT]) begin
          w_sel_nxt = nav_next(r_sel, NAV_SIDE);
        end
      end
      ST_ARMED: begin
        if (!w_lvl[BTN_SEL]) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_GAME;
      end
      ST_GAME: begin
        if (game_done) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!game_done && (w_lvl == '0)) w_state_nxt = ST_MENU;
      end
      default: begin
        w_state_nxt = ST_MENU;
      end
    endcase
  end

  // State and registered outputs, decoded from the state being entered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_MENU;
      r_sel     <= OPT_PLAY1P;
      r_mode    <= OPT_PLAY1P;
      r_start   <= 1'b0;
      r_in_game <= 1'b0;
      r_active  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_mode    <= w_mode_nxt;
      r_start   <= (w_state_nxt == ST_LAUNCH);
      r_in_game <= (w_state_nxt == ST_LAUNCH) || (w_state_nxt == ST_GAME);
      r_active  <= (w_state_nxt == ST_MENU) || (w_state_nxt == ST_ARMED);
    end
  end

  assign menu_sel    = r_sel;
  assign game_mode   = r_mode;
  assign game_start  = r_start;
  assign in_game     = r_in_game;
  assign menu_active = r_active;

endmodule

// File: tb/tb_menu_select_controller.sv
// tb/tb_menu_select_controller.sv - randomized bench for menu_select_controller against a behavioural model
module tb_menu_select_controller;

  localparam int D   = 4;
  localparam int WIN = D + 3;

  localparam int M_MENU   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_LAUNCH = 2;
  localparam int M_GAME   = 3;
  localparam int M_DRAIN  = 4;

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       btn_up     = 1'b0;
  logic       btn_down   = 1'b0;
  logic       btn_left   = 1'b0;
  logic       btn_right  = 1'b0;
  logic       btn_select = 1'b0;
  logic       game_done  = 1'b0;
  logic [2:0] menu_sel;
  logic       menu_active;
  logic [2:0] game_mode;
  logic       game_start;
  logic       in_game;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_st, m_sel, m_mode;
  bit m_start, m_in_game, m_active;
  bit m_lvl   [5];
  bit m_lvl_d [5];
  bit m_win   [5][WIN];

  // Cursor moves written out as plain lookup tables: index = current option.
  int up_tab   [5] = '{2, 0, 1, 4, 3};
  int down_tab [5] = '{1, 2, 0, 4, 3};
  int side_tab [5] = '{3, 4, 4, 0, 1};

  always #5 clock = ~clock;

  menu_select_controller #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (10)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_select  (btn_select),
    .game_done   (game_done),
    .menu_sel    (menu_sel),
    .menu_active (menu_active),
    .game_mode   (game_mode),
    .game_start  (game_start),
    .in_game     (in_game)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_MENU; m_sel = 0; m_mode = 0;
    m_start = 0; m_in_game = 0; m_active = 1;
    for (int b = 0; b < 5; b++) begin
      m_lvl[b] = 0; m_lvl_d[b] = 0;
      for (int k = 0; k < WIN; k++) m_win[b][k] = 0;
    end
  endtask

  // One rising edge of the reference: events come from levels settled before this edge;
  // a level flips once the synchronized input (2 edges late) has differed from it D+1 times running.
  task automatic model_edge();
    bit ev [5];
    bit raw [5];
    bit any_lvl;
    bit stable;
    if (!resetn) begin
      model_reset();
      return;
    end
    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_left; raw[3] = btn_right; raw[4] = btn_select;
    any_lvl = 0;
    for (int b = 0; b < 5; b++) begin
      ev[b] = m_lvl[b] && !m_lvl_d[b];
      if (m_lvl[b]) any_lvl = 1;
    end
    case (m_st)
      M_MENU: begin
        if (ev[4]) begin m_mode = m_sel; m_st = M_ARMED; end
        else if (ev[0]) m_sel = up_tab[m_sel];
        else if (ev[1]) m_sel = down_tab[m_sel];
        else if (ev[2] || ev[3]) m_sel = side_tab[m_sel];
      end
      M_ARMED:  if (!m_lvl[4]) m_st = M_LAUNCH;
      M_LAUNCH: m_st = M_GAME;
      M_GAME:   if (game_done) m_st = M_DRAIN;
      default:  if (!game_done && !any_lvl) m_st = M_MENU;
    endcase
    m_start   = (m_st == M_LAUNCH);
    m_in_game = (m_st == M_LAUNCH) || (m_st == M_GAME);
    m_active  = (m_st == M_MENU) || (m_st == M_ARMED);
    for (int b = 0; b < 5; b++) begin
      m_lvl_d[b] = m_lvl[b];
      for (int k = WIN - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
      m_win[b][0] = raw[b];
      stable = 1;
      for (int k = 2; k <= 2 + D; k++) if (m_win[b][k] == m_lvl[b]) stable = 0;
      if (stable) m_lvl[b] = !m_lvl[b];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("menu_sel", menu_sel, m_sel);
    check("game_mode", game_mode, m_mode);
    check("game_start", game_start, m_start);
    check("in_game", in_game, m_in_game);
    check("menu_active", menu_active, m_active);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      3: btn_right = v;
      default: btn_select = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1);
    ticks(hold);
    set_btn(b, 0);
    ticks(D + 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, menu_sel, 0);
    check({tag, "_mode"}, game_mode, 0);
    check({tag, "_start"}, game_start, 0);
    check({tag, "_in_game"}, in_game, 0);
    check({tag, "_active"}, menu_active, 1);
  endtask

  initial begin : stim
    int starts;
    int start_mode;
    int start_active;
    int start_in_game;
    int mask;
    int hold;

    model_reset();
    ticks(3);
    check_reset_outputs("reset");
    resetn = 1'b1;
    ticks(2);

    // Down wraps within the left column
    press(1, 10); check("sc1_down1", menu_sel, 1);
    press(1, 10); check("sc1_down2", menu_sel, 2);
    press(1, 10); check("sc1_down3", menu_sel, 0);

    // Column toggles
    press(1, 10); press(1, 10);
    press(3, 10); check("sc2_right_row2", menu_sel, 4);
    press(2, 10); check("sc2_left_4", menu_sel, 1);
    press(0, 10); press(3, 10); check("sc2_to3", menu_sel, 3);
    press(0, 10); check("sc2_up_3", menu_sel, 4);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      btn_down = ~btn_down;
      ticks(2);
    end
    btn_down = 1'b0;
    ticks(D + 8);
    check("sc3_bounce", menu_sel, 4);

    // Launch at option 1
    press(2, 10); check("sc4_pre", menu_sel, 1);
    btn_select = 1'b1;
    ticks(10);
    btn_select = 1'b0;
    starts = 0; start_mode = -1; start_active = -1; start_in_game = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (game_start === 1'b1) begin
        starts++;
        start_mode = game_mode; start_active = menu_active; start_in_game = in_game;
      end
    end
    check("sc4_start_count", starts, 1);
    check("sc4_mode", start_mode, 1);
    check("sc4_active", start_active, 0);
    check("sc4_in_game", start_in_game, 1);
    check("sc4_hold_in_game", in_game, 1);
    press(0, 10);
    check("sc4_ignored", menu_sel, 1);
    game_done = 1'b1; ticks(3);
    game_done = 1'b0; ticks(5);
    check("sc4_back_active", menu_active, 1);
    check("sc4_back_sel", menu_sel, 1);

    // Simultaneous up + select, then reset during GAME
    btn_up = 1'b1; btn_select = 1'b1;
    ticks(10);
    btn_up = 1'b0; btn_select = 1'b0;
    ticks(20);
    check("sc5_sel_kept", menu_sel, 1);
    check("sc5_mode", game_mode, 1);
    check("sc5_in_game", in_game, 1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("sc5_async");
    model_reset();
    ticks(2);
    resetn = 1'b1;
    ticks(2);

    // Long hold gives a single event in the default build
    press(1, 45);
    check("sc6_hold", menu_sel, 1);

    // Randomized phase
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 resetn = 1'b0;
        #1 check_reset_outputs("rnd_reset");
        model_reset();
        ticks(1);
        resetn = 1'b1;
      end
      mask = $urandom_range(0, 31);
      if ($urandom_range(0, 2) != 0) mask = 1 << $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) mask = 0;
      hold = $urandom_range(1, 12);
      btn_up     = mask[0];
      btn_down   = mask[1];
      btn_left   = mask[2];
      btn_right  = mask[3];
      btn_select = mask[4];
      game_done  = ($urandom_range(0, 3) == 0);
      ticks(hold);
    end
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_select = 0;
    game_done = 1'b1; ticks(D + 8);
    game_done = 1'b0; ticks(D + 8);
    check("final_active", menu_active, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
